ifu_fetch: RTL
==============

Name: ifu_fetch

Overview:
- Instruction-fetch initiator for the npc core. Owns the PC, issues word fetch requests to the instruction memory, and returns the instruction words.
- Buffers one fetched instruction, with its PC, toward the decode stage using a valid/ready handshake.
- Accepts branch/jump redirects from execute and discards any stale fetch that is still in flight.

Parameters:
- XLEN, 64, PC and address width (matches RegWidth).
- INST_W, 32, instruction width (matches InstWidth).
- PC_RST, 64'h8000_0000, PC value after reset (matches PcRst).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  XLEN  fetch address, always 4-byte aligned.
- imem_resp_valid  in  1  response word valid.
- imem_resp_inst  in  INST_W  response word.
- inst_valid  out  1  decode-side output valid.
- inst_ready  in  1  decode accepts the output.
- inst  out  INST_W  instruction to decode.
- inst_pc  out  XLEN  PC of `inst`.
- redirect_valid  in  1  PC redirect request.
- redirect_pc  in  XLEN  redirect target.

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=REQ, pc=PC_RST, drop=0, inst_valid=0, inst=0, inst_pc=0, imem_req_valid=0 during reset.
- Address rule: imem_req_addr = {pc[XLEN-1:2],2'b00}. Redirect targets have bits [1:0] zeroed.
- Sequential increment: pc+4, modulo 2^XLEN; wrap is silent.
- At most one outstanding request. Responses return in order, latency ≥1 cycle.
- Output buffer: a single entry (inst, inst_pc, inst_valid).
  - Outputs are registered and stable while inst_valid && !inst_ready.
  - The buffer is "free" when !inst_valid || inst_ready.
- State REQ:
  - imem_req_valid = 1 only when the buffer is free.
  - Handshake fires when imem_req_valid && imem_req_ready; on fire, go to WAIT.
  - A stalled request keeps addr constant until it fires.
- State WAIT:
  - imem_req_valid = 0.
  - On imem_resp_valid with drop=0: load the buffer (inst=imem_resp_inst, inst_pc=pc, inst_valid=1), pc<=pc+4, go to REQ.
  - The buffer is guaranteed free by the REQ gating.
  - On imem_resp_valid with drop=1: discard the word, clear drop, go to REQ. pc is unchanged because it already holds the redirect target.
- Steady-state throughput: 1 instruction per 2 cycles with 1-cycle memory latency.
- Redirect handling (highest priority, acts in the cycle redirect_valid=1):
  - pc<=redirect_pc; the buffer is flushed (inst_valid<=0) regardless of inst_ready.
  - In REQ without a fire: stay in REQ. The next request uses the new pc.
  - In REQ with a fire the same cycle: that request used the old pc; go to WAIT with drop<=1.
  - In WAIT without a response: drop<=1.
  - In WAIT with a response the same cycle: discard the response, drop stays 0, go to REQ.
  - Back-to-back redirects: the last one wins and drop stays 1 until the single outstanding response returns.
- Output handshake is simultaneous with a response: the buffer is consumed and refilled in the same cycle, with no bubble.
- A reset asserted mid-transaction abandons the in-flight request. Memory responses arriving after reset deasserts with state=REQ are ignored; they only count in WAIT.

Decomposition:
- Shared package/defines:
  - Existing PcRst, RegWidth, InstWidth macros.
  - Add IFU state encoding constants (IFU_REQ=1'b0, IFU_WAIT=1'b1).
  - Add the instruction-alignment constant (INST_ALIGN=2).
- One natural sub-module, ifu_outbuf: the single-entry valid/ready register slice with a flush input, reused later between the decode and execute stages.

Test Plan:
- Reset, memory with 1-cycle latency returning 0x00000013 at every address, inst_ready=1 → inst_pc sequence 0x80000000, 0x80000004, 0x80000008, with inst_valid high every 2nd cycle.
- Hold inst_ready=0 for 5 cycles after the first instruction → inst and inst_pc held at 0x00000013/0x80000000, no new imem_req fire. On release, next inst_pc is 0x80000004.
- redirect_valid with redirect_pc=0x80000102 while in WAIT → the in-flight response is discarded. The next fire has addr 0x80000100 and the first delivered inst_pc is 0x80000100.
- redirect_valid in the same cycle as a request fire (old addr 0x80000008), target 0x80000040 → the response for 0x80000008 is never presented. Next delivered inst_pc=0x80000040.
- redirect_valid coincident with imem_resp_valid → the response is discarded, the buffer is flushed, and the next addr is the target. No extra response is waited on.
- imem_req_ready held low 3 cycles → imem_req_addr stable; rst_n pulsed low mid-WAIT → inst_valid=0 immediately, and the next fire has addr 0x80000000.

Source files
------------

// File: rtl/ifu_fetch_pkg.sv
// Shared widths, reset PC and state encoding for the npc instruction-fetch unit.
package ifu_fetch_pkg;

  localparam int RegWidth  = 64;
  localparam int InstWidth = 32;
  localparam logic [RegWidth-1:0] PcRst = 64'h8000_0000;

  // Instructions are 4-byte aligned, so the low INST_ALIGN address bits are always zero.
  localparam int INST_ALIGN = 2;

  typedef enum logic {
    IFU_REQ  = 1'b0,
    IFU_WAIT = 1'b1
  } ifuState_e;

endpackage

// File: rtl/ifu_outbuf.sv
// Single-entry valid/ready register slice with a flush input, used between pipeline stages.
module ifu_outbuf
  import ifu_fetch_pkg::*;
#(
  parameter int XLEN   = RegWidth,
  parameter int INST_W = InstWidth
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              loadValid,
  input  logic [INST_W-1:0] loadInst,
  input  logic [XLEN-1:0]   loadPc,
  input  logic              outReady,
  output logic              outValid,
  output logic [INST_W-1:0] outInst,
  output logic [XLEN-1:0]   outPc,
  output logic              free
);

  // The slot can take a new entry when it is empty or being drained this cycle.
  assign free = !outValid || outReady;

  // Flush beats a load, a load refills in the same cycle as a drain, otherwise a drain empties the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid <= 1'b0;
      outInst  <= '0;
      outPc    <= '0;
    end else if (flush) begin
      outValid <= 1'b0;
    end else if (loadValid) begin
      outValid <= 1'b1;
      outInst  <= loadInst;
      outPc    <= loadPc;
    end else if (outReady) begin
      outValid <= 1'b0;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch initiator: owns the PC, issues one word request at a time and
// hands fetched instructions to decode, discarding stale fetches after a redirect.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int XLEN   = RegWidth,
  parameter int INST_W = InstWidth,
  parameter logic [XLEN-1:0] PC_RST = PcRst
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_inst,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   inst_pc,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc
);

  localparam logic [XLEN-1:0] PcStep    = XLEN'(1) << INST_ALIGN;
  localparam logic [XLEN-1:0] AlignMask = PcStep - XLEN'(1);

  ifuState_e       state;
  logic [XLEN-1:0] pc;
  logic            drop;
  logic            bufFree;
  logic            reqFire;
  logic            respAccept;
  logic            respLoad;
  logic [XLEN-1:0] redirectTarget;

  assign redirectTarget = redirect_pc & ~AlignMask;
  assign imem_req_addr  = pc & ~AlignMask;
  assign imem_req_valid = rst_n && (state == IFU_REQ) && bufFree;
  assign reqFire        = imem_req_valid && imem_req_ready;
  assign respAccept     = (state == IFU_WAIT) && imem_resp_valid;
  assign respLoad       = respAccept && !drop && !redirect_valid;

  // Request/response sequencing; a redirect replaces the PC and marks any still-outstanding fetch as stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IFU_REQ;
      pc    <= PC_RST;
      drop  <= 1'b0;
    end else begin
      case (state)
        IFU_REQ: begin
          if (reqFire) begin
            state <= IFU_WAIT;
            drop  <= redirect_valid;
          end
        end
        IFU_WAIT: begin
          if (respAccept) begin
            state <= IFU_REQ;
            drop  <= 1'b0;
          end else if (redirect_valid) begin
            drop  <= 1'b1;
          end
        end
        default: state <= IFU_REQ;
      endcase
      if (redirect_valid) begin
        pc <= redirectTarget;
      end else if (respLoad) begin
        pc <= pc + PcStep;
      end
    end
  end

  ifu_outbuf #(
    .XLEN  (XLEN),
    .INST_W(INST_W)
  ) uOutbuf (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_valid),
    .loadValid(respLoad),
    .loadInst (imem_resp_inst),
    .loadPc   (pc),
    .outReady (inst_ready),
    .outValid (inst_valid),
    .outInst  (inst),
    .outPc    (inst_pc),
    .free     (bufFree)
  );

endmodule
